irigb_bcd_sched: RTL and testbench

- Scheduler that converts one second's binary time fields (year, day-of-month, hour, minute, second, day-of-year) to packed BCD through a single shared iterative divide-by-10 unit.
- Sits between the TOD-to-calendar datapath and the IRIG-B frame encoder.
- Sequences the fields through the divider with a start/done handshake and commits all BCD outputs atomically once per conversion.

---
 rtl/irigb_bcd_sched_pkg.sv | 38 +++
 rtl/irigb_bcd_sched_div10.sv | 78 +++++++
 rtl/irigb_bcd_sched.sv | 203 ++++++++++++++++++++
 tb/tb_irigb_bcd_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irigb_bcd_sched_pkg.sv
// irigb_pkg: shared types, constants and helpers for the IRIG-B BCD scheduler.
//   state_t  - scheduler FSM states
//   op_t     - order in which fields pass through the shared divider
//   field limits used by the snapshot range check
//   in_range / bcd_value helpers
package irigb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

   typedef enum logic [2:0] {
      OP_YEAR, OP_DAY, OP_HOUR, OP_MIN, OP_SEC, OP_DOY_LO, OP_DOY_HI
   } op_t;

   localparam int NUM_OPS = 7;
   localparam int DIV_LAT = 9;

   localparam logic [8:0] YEAR_MAX = 9'd99;
   localparam logic [8:0] DAY_MIN  = 9'd1;
   localparam logic [8:0] DAY_MAX  = 9'd31;
   localparam logic [8:0] HOUR_MAX = 9'd23;
   localparam logic [8:0] MIN_MAX  = 9'd59;
   localparam logic [8:0] SEC_MAX  = 9'd60;
   localparam logic [8:0] DOY_MIN  = 9'd1;
   localparam logic [8:0] DOY_MAX  = 9'd366;

   function automatic logic in_range(input logic [8:0] v, input logic [8:0] lo,
                                     input logic [8:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   // 12 bits so that a bad hundreds digit cannot wrap back onto a valid value
   function automatic logic [11:0] bcd_value(input logic [3:0] hund,
                                             input logic [3:0] tens,
                                             input logic [3:0] ones);
      return 12'(hund) * 12'd100 + 12'(tens) * 12'd10 + 12'(ones);
   endfunction

endpackage

// File: rtl/irigb_bcd_sched_div10.sv
// bcd_div10_iter: restoring shift-subtract divide by 10, one quotient bit per
// clock. div_done pulses DIV_LAT cycles after div_start; quotient and
// remainder then hold until the next div_start.
//   clk_125m, rst       clock, async active-high reset
//   div_start           one-cycle request, dividend sampled with it
//   dividend[DIV_W-1:0] unsigned dividend
//   div_done            one-cycle completion pulse
//   quotient, remainder results
module bcd_div10_iter #(
   parameter int DIV_W   = 9,
   parameter int DIV_LAT = irigb_pkg::DIV_LAT
) (
   input  logic             clk_125m,
   input  logic             rst,
   input  logic             div_start,
   input  logic [DIV_W-1:0] dividend,
   output logic             div_done,
   output logic [DIV_W-1:0] quotient,
   output logic [3:0]       remainder
);

   // DIV_LAT must equal DIV_W: one dividend bit is consumed per cycle
   localparam int CNT_W = $clog2(DIV_LAT);

   logic [DIV_W-1:0] acc;
   logic [3:0]       rem;
   logic [CNT_W-1:0] cnt;
   logic             active;

   logic [DIV_W-1:0] src;
   logic [3:0]       rem_in;
   logic [4:0]       trial;
   logic             qbit;
   logic [3:0]       rem_next;

   // The first step runs on the start edge itself straight from the dividend,
   // which is what makes the latency DIV_LAT rather than DIV_LAT+1.
   always_comb begin
      src      = div_start ? dividend : acc;
      rem_in   = div_start ? 4'd0 : rem;
      trial    = {rem_in, src[DIV_W-1]};
      qbit     = (trial >= 5'd10);
      rem_next = qbit ? 4'(trial - 5'd10) : trial[3:0];
   end

   // acc starts as the dividend and fills with quotient bits from the right
   always_ff @(posedge clk_125m or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         rem      <= '0;
         cnt      <= '0;
         active   <= 1'b0;
         div_done <= 1'b0;
      end else begin
         div_done <= 1'b0;
         if (div_start || active) begin
            acc <= {src[DIV_W-2:0], qbit};
            rem <= rem_next;
         end
         if (div_start) begin
            active <= 1'b1;
            cnt    <= CNT_W'(DIV_LAT - 1);
         end else if (active) begin
            if (cnt == CNT_W'(1)) begin
               active   <= 1'b0;
               div_done <= 1'b1;
               cnt      <= '0;
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end
      end
   end

   assign quotient  = acc;
   assign remainder = rem;

endmodule

// File: rtl/irigb_bcd_sched.sv
// irigb_bcd_sched: converts one second's binary time fields to packed BCD
// through a single shared iterative divide-by-10, committing all outputs at
// once. A conversion takes 71 cycles after the start edge.
//   clk_125m, rst            clock, async active-high reset
//   start                    request; fields are snapshotted on this edge
//   *_bin                    binary fields (year, day, hour, min, sec, doy)
//   busy                     conversion in progress
//   done                     one-cycle pulse, BCD outputs valid from here
//   range_err                pulse with done; outputs were not updated
//   overrun                  start seen while busy (ignored)
//   *_bcd                    packed BCD results
// Build option: define IRIGB_BCD_CHECK_EN to reconstruct every field from its
// BCD digits before commit and reject the update on any disagreement.
module irigb_bcd_sched #(
   parameter int DIV_W   = 9,
   parameter int DIV_LAT = 9
) (
   input  logic        clk_125m,
   input  logic        rst,
   input  logic        start,
   input  logic [6:0]  year_bin,
   input  logic [4:0]  day_bin,
   input  logic [4:0]  hour_bin,
   input  logic [5:0]  min_bin,
   input  logic [5:0]  sec_bin,
   input  logic [8:0]  doy_bin,
   output logic        busy,
   output logic        done,
   output logic        range_err,
   output logic        overrun,
   output logic [7:0]  year_bcd,
   output logic [7:0]  day_bcd,
   output logic [7:0]  hour_bcd,
   output logic [7:0]  min_bcd,
   output logic [7:0]  sec_bcd,
   output logic [11:0] doy_bcd
);

   import irigb_pkg::*;

   state_t state;
   op_t    op;

   logic [6:0] year_s;
   logic [4:0] day_s, hour_s;
   logic [5:0] min_s, sec_s;
   logic [8:0] doy_s;

   logic [7:0]       year_sh, day_sh, hour_sh, min_sh, sec_sh;
   logic [3:0]       doy_ones_sh;
   logic [DIV_W-1:0] doy_q;

   logic             div_start, div_done;
   logic [DIV_W-1:0] div_dividend, div_quot;
   logic [3:0]       div_rem;

   logic        range_ok, commit_err;
   logic [11:0] final_doy;

   bcd_div10_iter #(.DIV_W(DIV_W), .DIV_LAT(DIV_LAT)) u_div (
      .clk_125m  (clk_125m),
      .rst       (rst),
      .div_start (div_start),
      .dividend  (div_dividend),
      .div_done  (div_done),
      .quotient  (div_quot),
      .remainder (div_rem)
   );

   assign div_start = (state == ISSUE);
   assign busy      = (state != IDLE);
   // Same-cycle rejection so the requester sees the overrun with its start
   assign overrun   = start && busy;

   // DOY_HI reuses the DOY_LO quotient, so the day-of-year is two divisions
   always_comb begin
      div_dividend = '0;
      case (op)
         OP_YEAR:   div_dividend = DIV_W'(year_s);
         OP_DAY:    div_dividend = DIV_W'(day_s);
         OP_HOUR:   div_dividend = DIV_W'(hour_s);
         OP_MIN:    div_dividend = DIV_W'(min_s);
         OP_SEC:    div_dividend = DIV_W'(sec_s);
         OP_DOY_LO: div_dividend = DIV_W'(doy_s);
         OP_DOY_HI: div_dividend = doy_q;
         default:   div_dividend = '0;
      endcase
   end

   always_comb begin
      range_ok = in_range(9'(year_s), 9'd0, YEAR_MAX)
              && in_range(9'(day_s), DAY_MIN, DAY_MAX)
              && in_range(9'(hour_s), 9'd0, HOUR_MAX)
              && in_range(9'(min_s), 9'd0, MIN_MAX)
              && in_range(9'(sec_s), 9'd0, SEC_MAX)
              && in_range(doy_s, DOY_MIN, DOY_MAX);
   end

   // The last division result is folded straight into the commit rather than
   // passing through the shadow registers first.
   assign final_doy = {div_quot[3:0], div_rem, doy_ones_sh};

`ifdef IRIGB_BCD_CHECK_EN
   logic recon_ok;

   always_comb begin
      recon_ok = (bcd_value(4'd0, year_sh[7:4], year_sh[3:0]) == 12'(year_s))
              && (bcd_value(4'd0, day_sh[7:4], day_sh[3:0]) == 12'(day_s))
              && (bcd_value(4'd0, hour_sh[7:4], hour_sh[3:0]) == 12'(hour_s))
              && (bcd_value(4'd0, min_sh[7:4], min_sh[3:0]) == 12'(min_s))
              && (bcd_value(4'd0, sec_sh[7:4], sec_sh[3:0]) == 12'(sec_s))
              && (bcd_value(final_doy[11:8], final_doy[7:4], final_doy[3:0])
                  == 12'(doy_s));
   end

   assign commit_err = !range_ok || !recon_ok;
`else
   assign commit_err = !range_ok;
`endif

   // Scheduler. The output registers load on the edge that enters COMMIT so
   // that done and the new values are visible together during COMMIT.
   always_ff @(posedge clk_125m or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         op          <= OP_YEAR;
         year_s      <= '0;
         day_s       <= '0;
         hour_s      <= '0;
         min_s       <= '0;
         sec_s       <= '0;
         doy_s       <= '0;
         year_sh     <= '0;
         day_sh      <= '0;
         hour_sh     <= '0;
         min_sh      <= '0;
         sec_sh      <= '0;
         doy_ones_sh <= '0;
         doy_q       <= '0;
         done        <= 1'b0;
         range_err   <= 1'b0;
         year_bcd    <= '0;
         day_bcd     <= '0;
         hour_bcd    <= '0;
         min_bcd     <= '0;
         sec_bcd     <= '0;
         doy_bcd     <= '0;
      end else begin
         done      <= 1'b0;
         range_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  year_s <= year_bin;
                  day_s  <= day_bin;
                  hour_s <= hour_bin;
                  min_s  <= min_bin;
                  sec_s  <= sec_bin;
                  doy_s  <= doy_bin;
                  op     <= OP_YEAR;
                  state  <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (div_done) begin
                  case (op)
                     OP_YEAR:   year_sh <= {div_quot[3:0], div_rem};
                     OP_DAY:    day_sh  <= {div_quot[3:0], div_rem};
                     OP_HOUR:   hour_sh <= {div_quot[3:0], div_rem};
                     OP_MIN:    min_sh  <= {div_quot[3:0], div_rem};
                     OP_SEC:    sec_sh  <= {div_quot[3:0], div_rem};
                     OP_DOY_LO: begin
                        doy_ones_sh <= div_rem;
                        doy_q       <= div_quot;
                     end
                     default: ;
                  endcase
                  if (op == op_t'(NUM_OPS - 1)) begin
                     if (!commit_err) begin
                        year_bcd <= year_sh;
                        day_bcd  <= day_sh;
                        hour_bcd <= hour_sh;
                        min_bcd  <= min_sh;
                        sec_bcd  <= sec_sh;
                        doy_bcd  <= final_doy;
                     end
                     done      <= 1'b1;
                     range_err <= commit_err;
                     state     <= COMMIT;
                  end else begin
                     op    <= op_t'(op + 3'd1);
                     state <= ISSUE;
                  end
               end
            end
            COMMIT: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irigb_bcd_sched.sv
// tb_irigb_bcd_sched: self-checking bench for irigb_bcd_sched.
// Cycle n is the clock period that follows rising edge n; start is driven in
// cycle 0, so done is expected in cycle 71 and busy in cycles 1..71.
// Expected results are queued when a conversion is started and compared by a
// monitor whenever the DUT pulses done.
`timescale 1ns/1ps
module tb_irigb_bcd_sched;

   typedef struct {
      int y; int d; int h; int m; int s; int doy;
   } fields_t;

   typedef struct {
      logic [7:0]  y;
      logic [7:0]  d;
      logic [7:0]  h;
      logic [7:0]  m;
      logic [7:0]  s;
      logic [11:0] doy;
      logic        err;
   } exp_t;

   typedef struct {
      fields_t f;
      exp_t    e;
   } vec_t;

   logic        clk_125m = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [6:0]  year_bin;
   logic [4:0]  day_bin, hour_bin;
   logic [5:0]  min_bin, sec_bin;
   logic [8:0]  doy_bin;
   logic        busy, done, range_err, overrun;
   logic [7:0]  year_bcd, day_bcd, hour_bcd, min_bcd, sec_bcd;
   logic [11:0] doy_bcd;

   irigb_bcd_sched dut (
      .clk_125m  (clk_125m),
      .rst       (rst),
      .start     (start),
      .year_bin  (year_bin),
      .day_bin   (day_bin),
      .hour_bin  (hour_bin),
      .min_bin   (min_bin),
      .sec_bin   (sec_bin),
      .doy_bin   (doy_bin),
      .busy      (busy),
      .done      (done),
      .range_err (range_err),
      .overrun   (overrun),
      .year_bcd  (year_bcd),
      .day_bcd   (day_bcd),
      .hour_bcd  (hour_bcd),
      .min_bcd   (min_bcd),
      .sec_bcd   (sec_bcd),
      .doy_bcd   (doy_bcd)
   );

   always #4 clk_125m = ~clk_125m;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   exp_t exp_last;
   exp_t mon_e;
   vec_t tbl[10];

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic apply_stimulus(input fields_t f);
      year_bin = 7'(f.y);
      day_bin  = 5'(f.d);
      hour_bin = 5'(f.h);
      min_bin  = 6'(f.m);
      sec_bin  = 6'(f.s);
      doy_bin  = 9'(f.doy);
   endtask

   task automatic apply_random();
      year_bin = 7'($urandom());
      day_bin  = 5'($urandom());
      hour_bin = 5'($urandom());
      min_bin  = 6'($urandom());
      sec_bin  = 6'($urandom());
      doy_bin  = 9'($urandom());
   endtask

   // Reference conversion: decimal digits by plain integer arithmetic; an
   // out-of-range field leaves the last committed values in place.
   function automatic exp_t model(input fields_t f);
      exp_t e;
      bit   ok;
      ok = (f.y <= 99) && (f.d >= 1) && (f.d <= 31) && (f.h <= 23)
        && (f.m <= 59) && (f.s <= 60) && (f.doy >= 1) && (f.doy <= 366);
      if (ok) begin
         e.y   = 8'((f.y / 10) * 16 + f.y % 10);
         e.d   = 8'((f.d / 10) * 16 + f.d % 10);
         e.h   = 8'((f.h / 10) * 16 + f.h % 10);
         e.m   = 8'((f.m / 10) * 16 + f.m % 10);
         e.s   = 8'((f.s / 10) * 16 + f.s % 10);
         e.doy = 12'((f.doy / 100) * 256 + ((f.doy / 10) % 10) * 16 + f.doy % 10);
      end else begin
         e = exp_last;
      end
      e.err = !ok;
      return e;
   endfunction

   // Compare committed results against the queue whenever done pulses
   always @(negedge clk_125m) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            check_output("spurious_done", 32'(done), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check_output("year_bcd", 32'(year_bcd), 32'(mon_e.y));
            check_output("day_bcd", 32'(day_bcd), 32'(mon_e.d));
            check_output("hour_bcd", 32'(hour_bcd), 32'(mon_e.h));
            check_output("min_bcd", 32'(min_bcd), 32'(mon_e.m));
            check_output("sec_bcd", 32'(sec_bcd), 32'(mon_e.s));
            check_output("doy_bcd", 32'(doy_bcd), 32'(mon_e.doy));
            check_output("range_err_at_done", 32'(range_err), 32'(mon_e.err));
         end
      end else if (!rst && range_err) begin
         check_output("range_err_without_done", 32'(range_err), 32'd0);
      end
   end

   // One conversion: start in cycle 0, then watch 80 cycles for the done
   // pulse, busy window and (optionally) overrun responses to extra starts.
   task automatic run_conv(input fields_t f, input exp_t e, input bit scramble,
                           input bit extra, input string tag);
      int      done_cyc;
      int      n_done;
      fields_t fx;
      sb.push_back(e);
      if (!e.err) exp_last = e;
      @(posedge clk_125m); #1;
      apply_stimulus(f);
      start = 1'b1;
      @(negedge clk_125m);
      check_output({tag, "_overrun_idle"}, 32'(overrun), 32'd0);
      done_cyc = -1;
      n_done   = 0;
      for (int c = 1; c <= 80; c++) begin
         @(posedge clk_125m); #1;
         start = extra && (c == 30 || c == 71);
         if (start) begin
            fx = (c == 30) ? '{1, 1, 1, 1, 1, 1} : '{2, 2, 2, 2, 2, 2};
            apply_stimulus(fx);
         end else if (scramble) begin
            apply_random();
         end
         @(negedge clk_125m);
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c == 1 || c == 71) check_output($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'd1);
         if (c == 72) check_output({tag, "_busy_c72"}, 32'(busy), 32'd0);
         if (extra && (c == 29 || c == 30 || c == 31 || c == 71 || c == 72))
            check_output($sformatf("%s_overrun_c%0d", tag, c), 32'(overrun),
                         (c == 30 || c == 71) ? 32'd1 : 32'd0);
      end
      start = 1'b0;
      check_output({tag, "_done_cycle"}, 32'(done_cyc), 32'd71);
      check_output({tag, "_done_count"}, 32'(n_done), 32'd1);
   endtask

   initial begin
      fields_t f;
      exp_t    e;
      int      n_done;

      rst      = 1'b1;
      start    = 1'b0;
      exp_last = '{default: 0};
      f        = '{0, 1, 0, 0, 0, 1};
      apply_stimulus(f);
      repeat (3) @(posedge clk_125m);
      @(negedge clk_125m);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_done", 32'(done), 32'd0);
      check_output("reset_year", 32'(year_bcd), 32'd0);
      check_output("reset_doy", 32'(doy_bcd), 32'd0);
      @(posedge clk_125m); #1;
      rst = 1'b0;

      // Error rows list the previously committed values they must leave alone
      tbl[0] = '{'{24, 29, 23, 59, 60, 366}, '{8'h24, 8'h29, 8'h23, 8'h59, 8'h60, 12'h366, 1'b0}};
      tbl[1] = '{'{0, 1, 0, 0, 0, 1},        '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 12'h001, 1'b0}};
      tbl[2] = '{'{99, 31, 0, 0, 0, 100},    '{8'h99, 8'h31, 8'h00, 8'h00, 8'h00, 12'h100, 1'b0}};
      tbl[3] = '{'{7, 15, 24, 30, 45, 200},  '{8'h99, 8'h31, 8'h00, 8'h00, 8'h00, 12'h100, 1'b1}};
      tbl[4] = '{'{50, 10, 12, 34, 56, 45},  '{8'h50, 8'h10, 8'h12, 8'h34, 8'h56, 12'h045, 1'b0}};
      tbl[5] = '{'{0, 0, 1, 1, 1, 10},       '{8'h50, 8'h10, 8'h12, 8'h34, 8'h56, 12'h045, 1'b1}};
      tbl[6] = '{'{100, 5, 5, 5, 5, 5},      '{8'h50, 8'h10, 8'h12, 8'h34, 8'h56, 12'h045, 1'b1}};
      tbl[7] = '{'{1, 1, 1, 1, 61, 1},       '{8'h50, 8'h10, 8'h12, 8'h34, 8'h56, 12'h045, 1'b1}};
      tbl[8] = '{'{1, 1, 1, 1, 1, 367},      '{8'h50, 8'h10, 8'h12, 8'h34, 8'h56, 12'h045, 1'b1}};
      tbl[9] = '{'{10, 20, 9, 9, 9, 9},      '{8'h10, 8'h20, 8'h09, 8'h09, 8'h09, 12'h009, 1'b0}};

      for (int i = 0; i < 10; i++)
         run_conv(tbl[i].f, tbl[i].e, 1'b0, 1'b0, $sformatf("vec%0d", i));

      // Extra starts at cycles 30 and 71 are rejected; results come from cycle 0
      $display("[TB] overrun sequence");
      f = '{45, 12, 8, 30, 15, 250};
      e = model(f);
      run_conv(f, e, 1'b0, 1'b1, "ovr");

      // Inputs churn every cycle after the start; only the snapshot matters
      $display("[TB] input scramble sequence");
      f = '{12, 5, 6, 7, 8, 100};
      e = model(f);
      run_conv(f, e, 1'b1, 1'b0, "scr");
      check_output("scr_doy_hold", 32'(doy_bcd), 32'h100);
      check_output("scr_min_hold", 32'(min_bcd), 32'h07);

      // Reset in the middle of a conversion clears everything, no done follows
      $display("[TB] mid-conversion reset sequence");
      @(posedge clk_125m); #1;
      f = '{33, 3, 3, 3, 3, 333};
      apply_stimulus(f);
      start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk_125m); #1;
         start = 1'b0;
         if (c == 40) rst = 1'b1;
      end
      @(negedge clk_125m);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_year", 32'(year_bcd), 32'd0);
      check_output("rst_sec", 32'(sec_bcd), 32'd0);
      check_output("rst_doy", 32'(doy_bcd), 32'd0);
      exp_last = '{default: 0};
      @(posedge clk_125m); #1;
      rst    = 1'b0;
      n_done = 0;
      repeat (80) begin
         @(negedge clk_125m);
         if (done) n_done++;
      end
      check_output("rst_no_done", 32'(n_done), 32'd0);
      f = '{8, 17, 4, 5, 6, 58};
      e = model(f);
      run_conv(f, e, 1'b0, 1'b0, "post_rst");

      check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
